beat_timing_gen: RTL and testbench
==================================

// Module: beat_timing_gen
// PURPOSE
//   Machine-cycle beat generator feeding the hardwired controller (cpu). Produces the
//   one-hot beat strobes w1/w2/w3 and the t3 phase strobe the controller consumes.
//   Consumes the controller's short/long/stop requests to shorten, extend or halt the
//   cycle. Runs from the qd start pulse; returns to idle on stop.
// PARAMETERS
//   T_PER_W   4   clock cycles per beat (phases 0..T_PER_W-1), legal range >=2
//   T3_PHASE  2   phase index (0-based) during which t3 is high, < T_PER_W
//   CNT_W     16  width of free-running beat counter
// PORTS
//   clk       in   1      single system clock, all logic on rising edge
//   clr       in   1      reset, synchronous, active-high
//   qd        in   1      start pulse (button level, already debounced)
//   short     in   1      from controller: W1 is the last beat of this machine cycle
//   long      in   1      from controller: extend cycle with W3 after W2
//   stop      in   1      from controller: halt after current beat
//   w1,w2,w3  out  1 each one-hot beat strobes, all 0 when idle
//   t3        out  1      high for exactly one clk in phase T3_PHASE of every active beat
//   beat_end  out  1      high in the last phase (T_PER_W-1) of every active beat
//   running   out  1      1 while a beat is active
//   beat_cnt  out  CNT_W  number of completed beats since reset, wraps to 0
// BEHAVIOUR
//   Reset (clr=1 at an edge): state=IDLE, phase=0. w1=w2=w3=t3=beat_end=running=0,
//     beat_cnt=0, qd_q=1. Presetting qd_q to 1 means a qd already held high does not start.
//   All outputs are registered or pure decodes of state/phase registers; no input reaches
//     an output combinationally.
//   States: IDLE, W1, W2, W3 (w_i=1 iff state==Wi; running = state!=IDLE).
//   IDLE: qd rising edge (qd & ~qd_q) seen at edge n -> state=W1, phase=0 after edge n,
//     so w1 is high in the following cycle. A qd edge outside IDLE is ignored.
//   In Wx: phase increments each clk. t3 = (phase==T3_PHASE). beat_end = (phase==T_PER_W-1).
//   At beat_end (the only sampling point for short/long/stop), phase->0, beat_cnt+=1
//     (wrapping), and the next state is:
//       stop=1          -> IDLE (the current beat always completes in full)
//       W1: short=1 -> W1, else -> W2  (long ignored in W1; short wins over long)
//       W2: long=1  -> W3, else -> W1  (short ignored in W2)
//       W3:              -> W1
//   Changes to short/long/stop between sampling points have no effect.
//   clr mid-beat: the beat is abandoned and the reset values apply after that edge;
//     beat_cnt is cleared.
// STRUCTURE
//   timing_pkg: typedef enum logic [1:0] {BEAT_IDLE, BEAT_W1, BEAT_W2, BEAT_W3} beat_e;
//     default constants for T_PER_W / T3_PHASE; shared with the cpu testbench.
//   Sub-module pulse_edge_det (clk, clr, din, rise): registered rising-edge detector
//     with reset value 1. Used for qd.
//   Top holds the state register, the phase counter ($clog2(T_PER_W) bits) and beat_cnt.
// TESTING (defaults T_PER_W=4, T3_PHASE=2)
//   1 clr, then qd 0->1, short=long=stop=0 -> w1 4 clk, w2 4 clk, w1 again.
//     t3 high in the 3rd clk of each beat; beat_cnt=2 after 8 clk.
//   2 short=1 held, 24 clk run -> only w1 ever high; beat_cnt=6; beat_end every 4th clk.
//   3 long=1 held -> W1,W2,W3,W1 repeating with 12-clk period. Then short=long=1 -> W1 repeats.
//   4 stop=1 pulsed at W2 phase 1 only -> ignored, W1 follows. stop held through W2 phase 3
//     -> W2 completes, then w*=0 and running=0. New qd edge -> resumes at W1.
//   5 clr in W3 phase 1 with qd held high -> after that edge all outputs 0 and beat_cnt=0.
//     Still idle until qd goes 0 then 1.
//   6 qd toggled while running -> beat sequence and beat_cnt unchanged vs. golden model.

Source files
------------

// File: rtl/timing_pkg.sv
// Shared types and default timing constants for the machine-cycle beat generator.
package timing_pkg;

   typedef enum logic [1:0] {BEAT_IDLE, BEAT_W1, BEAT_W2, BEAT_W3} beat_e;

   localparam int unsigned T_PER_W_DEF  = 4;
   localparam int unsigned T3_PHASE_DEF = 2;
   localparam int unsigned CNT_W_DEF    = 16;

endpackage

// File: rtl/pulse_edge_det.sv
// Rising-edge detector; the history flop resets high so a level already high at reset is not an edge.
module pulse_edge_det (
   input  logic i_clk,
   input  logic i_clr,
   input  logic i_din,
   output logic o_rise_c
);

   logic r_din_q;

   always_ff @(posedge i_clk) begin
      if (i_clr) r_din_q <= 1'b1;
      else       r_din_q <= i_din;
   end

   assign o_rise_c = i_din & ~r_din_q;

endmodule

// File: rtl/beat_timing_gen.sv
// Beat generator for the hardwired controller: W1/W2/W3 beat strobes, t3 phase strobe,
// beat_end marker and completed-beat counter; short/long/stop sampled only at beat_end.
module beat_timing_gen
   import timing_pkg::*;
#(
   parameter int unsigned T_PER_W  = T_PER_W_DEF,
   parameter int unsigned T3_PHASE = T3_PHASE_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_qd,
   input  logic             i_short,
   input  logic             i_long,
   input  logic             i_stop,
   output logic             o_w1,
   output logic             o_w2,
   output logic             o_w3,
   output logic             o_t3,
   output logic             o_beat_end,
   output logic             o_running,
   output logic [CNT_W-1:0] o_beat_cnt
);

   localparam int unsigned PH_W = $clog2(T_PER_W);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(T_PER_W - 1);
   localparam logic [PH_W-1:0] PH_T3   = PH_W'(T3_PHASE);

   beat_e            r_state, w_nxt_state;
   logic [PH_W-1:0]  r_phase, w_nxt_phase;
   logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
   logic             w_qd_rise;
   logic             w_w1, w_w2, w_w3, w_t3, w_beat_end, w_running;
   logic             r_w1, r_w2, r_w3, r_t3, r_beat_end, r_running;

   pulse_edge_det u_qd_edge (
      .i_clk    (i_clk),
      .i_clr    (i_clr),
      .i_din    (i_qd),
      .o_rise_c (w_qd_rise)
   );

   // State, phase, counter and output registers; outputs follow the next state/phase.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_state    <= BEAT_IDLE;
         r_phase    <= '0;
         r_cnt      <= '0;
         r_w1       <= 1'b0;
         r_w2       <= 1'b0;
         r_w3       <= 1'b0;
         r_t3       <= 1'b0;
         r_beat_end <= 1'b0;
         r_running  <= 1'b0;
      end else begin
         r_state    <= w_nxt_state;
         r_phase    <= w_nxt_phase;
         r_cnt      <= w_nxt_cnt;
         r_w1       <= w_w1;
         r_w2       <= w_w2;
         r_w3       <= w_w3;
         r_t3       <= w_t3;
         r_beat_end <= w_beat_end;
         r_running  <= w_running;
      end
   end

   // Next state: qd edge starts from idle; beat sequencing decided only in the last phase.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_phase = r_phase;
      w_nxt_cnt   = r_cnt;
      if (r_state == BEAT_IDLE) begin
         if (w_qd_rise) begin
            w_nxt_state = BEAT_W1;
            w_nxt_phase = '0;
         end
      end else if (r_phase == PH_LAST) begin
         w_nxt_phase = '0;
         w_nxt_cnt   = r_cnt + CNT_W'(1);
         if (i_stop) begin
            w_nxt_state = BEAT_IDLE;
         end else begin
            unique case (r_state)
               BEAT_W1: w_nxt_state = i_short ? BEAT_W1 : BEAT_W2;
               BEAT_W2: w_nxt_state = i_long  ? BEAT_W3 : BEAT_W1;
               default: w_nxt_state = BEAT_W1;
            endcase
         end
      end else begin
         w_nxt_phase = r_phase + PH_W'(1);
      end
   end

   // Output decode of the upcoming state/phase.
   always_comb begin
      w_running  = (w_nxt_state != BEAT_IDLE);
      w_w1       = (w_nxt_state == BEAT_W1);
      w_w2       = (w_nxt_state == BEAT_W2);
      w_w3       = (w_nxt_state == BEAT_W3);
      w_t3       = w_running && (w_nxt_phase == PH_T3);
      w_beat_end = w_running && (w_nxt_phase == PH_LAST);
   end

   assign o_w1       = r_w1;
   assign o_w2       = r_w2;
   assign o_w3       = r_w3;
   assign o_t3       = r_t3;
   assign o_beat_end = r_beat_end;
   assign o_running  = r_running;
   assign o_beat_cnt = r_cnt;

endmodule

// File: tb/tb_beat_timing_gen.sv
// Bench for beat_timing_gen: directed scenarios plus random stimulus against a cycle model.
module tb_beat_timing_gen;
   import timing_pkg::*;

   localparam int T  = 4;
   localparam int T3 = 2;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          i_clr = 1'b1, i_qd = 1'b0, i_short = 1'b0, i_long = 1'b0, i_stop = 1'b0;
   logic          o_w1, o_w2, o_w3, o_t3, o_beat_end, o_running;
   logic [CW-1:0] o_beat_cnt;
   logic [5:0]    dut_vec;

   int checks = 0;
   int errors = 0;

   beat_timing_gen #(.T_PER_W(T), .T3_PHASE(T3), .CNT_W(CW)) dut (
      .i_clk(clk), .i_clr(i_clr), .i_qd(i_qd), .i_short(i_short), .i_long(i_long),
      .i_stop(i_stop), .o_w1(o_w1), .o_w2(o_w2), .o_w3(o_w3), .o_t3(o_t3),
      .o_beat_end(o_beat_end), .o_running(o_running), .o_beat_cnt(o_beat_cnt)
   );

   always #5 clk = ~clk;

   assign dut_vec = {o_w1, o_w2, o_w3, o_t3, o_beat_end, o_running};

   // Reference model: which beat (1..3) is active, position inside it, completed beats.
   bit m_active = 1'b0;
   int m_beat = 0;
   int m_ph = 0;
   int m_cnt = 0;
   bit m_qd_prev = 1'b1;

   always @(posedge clk) begin
      if (i_clr) begin
         m_active = 1'b0; m_beat = 0; m_ph = 0; m_cnt = 0; m_qd_prev = 1'b1;
      end else begin
         if (!m_active) begin
            if (i_qd && !m_qd_prev) begin
               m_active = 1'b1; m_beat = 1; m_ph = 0;
            end
         end else if (m_ph == T - 1) begin
            m_ph  = 0;
            m_cnt = (m_cnt + 1) % 65536;
            if (i_stop)           m_active = 1'b0;
            else if (m_beat == 1) m_beat = i_short ? 1 : 2;
            else if (m_beat == 2) m_beat = i_long ? 3 : 1;
            else                  m_beat = 1;
         end else begin
            m_ph++;
         end
         m_qd_prev = i_qd;
      end
   end

   function automatic logic [5:0] exp_vec();
      return {m_active && m_beat == 1, m_active && m_beat == 2, m_active && m_beat == 3,
              m_active && m_ph == T3, m_active && m_ph == T - 1, m_active};
   endfunction

   // Reset, then qd low then high; returns at the first cycle showing w1.
   task automatic do_start();
      @(negedge clk); i_clr = 1'b1;
      @(negedge clk); i_clr = 1'b0; i_qd = 1'b0;
      @(negedge clk); i_qd = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      i_qd = 1'b1; i_clr = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (dut_vec !== 6'b0 || o_beat_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_values got %b cnt %0d exp 000000 cnt 0", dut_vec, o_beat_cnt);
      end
      i_clr = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (o_running !== 1'b0 || dut_vec !== exp_vec()) begin
         errors++; $display("FAIL reset_qd_held got %b exp 000000", dut_vec);
      end
   endtask

   task automatic test_basic();
      logic [3:0] exp_wt;
      i_short = 0; i_long = 0; i_stop = 0;
      do_start();
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec() || o_beat_cnt !== CW'(m_cnt)) begin
            errors++; $display("FAIL basic_model k=%0d got %b cnt %0d exp %b cnt %0d", k, dut_vec, o_beat_cnt, exp_vec(), m_cnt);
         end
         exp_wt = {(k < 4 || k >= 8) ? 3'b100 : 3'b010, (k % 4) == 2};
         checks++;
         if ({o_w1, o_w2, o_w3, o_t3} !== exp_wt) begin
            errors++; $display("FAIL basic_seq k=%0d got %b exp %b", k, {o_w1, o_w2, o_w3, o_t3}, exp_wt);
         end
      end
      checks++;
      if (o_beat_cnt !== 16'd2) begin
         errors++; $display("FAIL basic_cnt got %0d exp 2", o_beat_cnt);
      end
   endtask

   task automatic test_short();
      int be_seen = 0;
      i_short = 1'b1;
      do_start();
      for (int k = 0; k <= 24; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec() || o_beat_cnt !== CW'(m_cnt) || o_w2 || o_w3) begin
            errors++; $display("FAIL short_model k=%0d got %b cnt %0d exp %b cnt %0d", k, dut_vec, o_beat_cnt, exp_vec(), m_cnt);
         end
         if (k < 24 && o_beat_end) be_seen++;
      end
      checks++;
      if (o_beat_cnt !== 16'd6 || be_seen != 6) begin
         errors++; $display("FAIL short_count got cnt %0d be %0d exp 6 6", o_beat_cnt, be_seen);
      end
      i_short = 1'b0;
   endtask

   task automatic test_long();
      logic [5:0] hist [48];
      i_long = 1'b1;
      do_start();
      for (int k = 0; k < 48; k++) begin
         if (k > 0) @(negedge clk);
         hist[k] = dut_vec;
         checks++;
         if (dut_vec !== exp_vec() || o_beat_cnt !== CW'(m_cnt)) begin
            errors++; $display("FAIL long_model k=%0d got %b exp %b", k, dut_vec, exp_vec());
         end
         if (k >= 12) begin
            checks++;
            if (hist[k] !== hist[k-12]) begin
               errors++; $display("FAIL long_period k=%0d got %b exp %b", k, hist[k], hist[k-12]);
            end
         end
         if (k == 9) begin
            checks++;
            if (o_w3 !== 1'b1) begin
               errors++; $display("FAIL long_w3 got %b exp 1", o_w3);
            end
         end
      end
      i_short = 1'b1;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec() || o_w2 || o_w3) begin
            errors++; $display("FAIL short_long k=%0d got %b exp %b", k, dut_vec, exp_vec());
         end
      end
      i_short = 1'b0; i_long = 1'b0;
   endtask

   task automatic test_stop();
      do_start();
      for (int k = 0; k <= 17; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec() || o_beat_cnt !== CW'(m_cnt)) begin
            errors++; $display("FAIL stop_model k=%0d got %b cnt %0d exp %b cnt %0d", k, dut_vec, o_beat_cnt, exp_vec(), m_cnt);
         end
         if (k == 8 || k == 16 || k == 17) begin
            checks++;
            if ((k == 8 && o_w1 !== 1'b1) || (k >= 16 && (o_running !== 1'b0 || o_beat_cnt !== 16'd4))) begin
               errors++; $display("FAIL stop_dir k=%0d got %b cnt %0d", k, dut_vec, o_beat_cnt);
            end
         end
         if (k == 5)  i_stop = 1'b1;
         if (k == 6)  i_stop = 1'b0;
         if (k == 13) i_stop = 1'b1;
         if (k == 16) i_stop = 1'b0;
      end
      i_qd = 1'b0;
      @(negedge clk); i_qd = 1'b1;
      @(negedge clk);
      checks++;
      if (o_w1 !== 1'b1 || dut_vec !== exp_vec()) begin
         errors++; $display("FAIL stop_resume got %b exp %b", dut_vec, exp_vec());
      end
   endtask

   task automatic test_clr_mid();
      i_long = 1'b1;
      do_start();
      for (int k = 0; k <= 9; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL clr_pre k=%0d got %b exp %b", k, dut_vec, exp_vec());
         end
      end
      i_clr = 1'b1;
      @(negedge clk);
      i_clr = 1'b0; i_long = 1'b0;
      checks++;
      if (dut_vec !== 6'b0 || o_beat_cnt !== 16'd0) begin
         errors++; $display("FAIL clr_mid got %b cnt %0d exp 000000 cnt 0", dut_vec, o_beat_cnt);
      end
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (o_running !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL clr_idle got %b exp 000000", dut_vec);
         end
      end
      i_qd = 1'b0;
      @(negedge clk); i_qd = 1'b1;
      @(negedge clk);
      checks++;
      if (o_w1 !== 1'b1 || o_beat_cnt !== 16'd0) begin
         errors++; $display("FAIL clr_restart got w1 %b cnt %0d exp 1 0", o_w1, o_beat_cnt);
      end
   endtask

   task automatic test_random(input int cycles, input bit with_clr);
      do_start();
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec() || o_beat_cnt !== CW'(m_cnt)) begin
            errors++; $display("FAIL random k=%0d got %b cnt %0d exp %b cnt %0d", k, dut_vec, o_beat_cnt, exp_vec(), m_cnt);
         end
         i_qd    = 1'($urandom_range(0, 1));
         i_short = 1'($urandom_range(0, 1));
         i_long  = 1'($urandom_range(0, 1));
         i_stop  = ($urandom_range(0, 39) == 0);
         i_clr   = with_clr && ($urandom_range(0, 149) == 0);
      end
      i_clr = 1'b0; i_stop = 1'b0; i_short = 1'b0; i_long = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short();
      test_long();
      test_stop();
      test_clr_mid();
      test_random(300, 1'b0);
      test_random(400, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
